// File: rtl/apb_upsizer_pkg.sv
// apb_upsizer_pkg
//   Shared types and constants for the 16-bit to 32-bit APB upsizer.
//   state_t : bridge FSM states.
//   op_t    : master-side operation (read / write).
//   PH_*    : master phase numbers within one flush / RMW / access chain.
//             0 = flush read, 1 = flush write, 2 = first main phase,
//             3 = second main phase (the write half of a read-modify-write).
package apb_upsizer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    M_SETUP  = 2'd1,
    M_ACCESS = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int ADDR_W    = 8;
  localparam int SDATA_W   = 16;
  localparam int MDATA_W   = 32;
  localparam int WADDR_LSB = 2;

  localparam logic [1:0] PH_FLUSH_RD = 2'd0;
  localparam logic [1:0] PH_FLUSH_WR = 2'd1;
  localparam logic [1:0] PH_MAIN0    = 2'd2;
  localparam logic [1:0] PH_MAIN1    = 2'd3;

endpackage

// File: rtl/apb_upsizer_mport.sv
// apb_upsizer_mport
//   Runs one APB master transfer (SETUP then ACCESS, held until pready_i).
//   A start_i pulse loads op/address/data and raises psel in the next cycle;
//   penable follows one cycle later. done_o is high in the cycle the completer
//   finishes (penable & pready); read data is captured on that edge.
//   start_i may be asserted in the done_o cycle to chain straight into the
//   SETUP of the next transfer.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start_i             begin a transfer with op_i / addr_i / wdata_i
//   op_i, addr_i, wdata_i  transfer command
//   pready_i, prdata_i  completer response
//   psel_o, penable_o, pwrite_o, paddr_o, pwdata_o  master APB outputs
//   done_o              transfer completes this cycle
//   rdata_o             data captured at the last completion
module apb_upsizer_mport
  import apb_upsizer_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = MDATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  op_t           op_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pready_i,
  input  logic [DW-1:0] prdata_i,
  output logic          psel_o,
  output logic          penable_o,
  output logic          pwrite_o,
  output logic [AW-1:0] paddr_o,
  output logic [DW-1:0] pwdata_o,
  output logic          done_o,
  output logic [DW-1:0] rdata_o
);

  logic          psel_q;
  logic          penable_q;
  logic          pwrite_q;
  logic [AW-1:0] paddr_q;
  logic [DW-1:0] pwdata_q;
  logic [DW-1:0] rdata_q;

  assign done_o = psel_q && penable_q && pready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
    end else begin
      if (done_o) begin
        psel_q    <= 1'b0;
        penable_q <= 1'b0;
        rdata_q   <= prdata_i;
      end else if (psel_q && !penable_q) begin
        penable_q <= 1'b1;
      end
      // A chained start overrides the end-of-transfer clear above.
      if (start_i) begin
        psel_q    <= 1'b1;
        penable_q <= 1'b0;
        pwrite_q  <= (op_i == OP_WR);
        paddr_q   <= addr_i;
        pwdata_q  <= wdata_i;
      end
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign rdata_o   = rdata_q;

endmodule

// File: rtl/apb_upsizer.sv
// apb_upsizer
//   Bridges a 16-bit APB requester (suffix s) onto a 32-bit APB completer
//   (suffix m). Low-half writes are parked in a one-entry buffer and merged
//   with the following high-half write of the same word; lone high halves are
//   merged by read-modify-write. Any access that conflicts with a parked low
//   half first flushes it (read word, write {rd[31:16], wbuf}).
//   Optional macro APB_UPSIZER_RCACHE_EN keeps the upper half of the last
//   low-half read so that the following high-half read needs no master access.
// Ports:
//   PCLK, PRESET                     clock, asynchronous active-high reset
//   PSELs, PENABLEs, PWRITEs, PADDRs, PWDATAs -> PRDATAs, PREADYs   16-bit side
//   PSELm, PENABLEm, PWRITEm, PADDRm, PWDATAm <- PRDATAm, PREADYm   32-bit side
module apb_upsizer #(
  parameter int ADDR_W  = apb_upsizer_pkg::ADDR_W,
  parameter int SDATA_W = apb_upsizer_pkg::SDATA_W,
  parameter int MDATA_W = apb_upsizer_pkg::MDATA_W
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic               PSELs,
  input  logic               PENABLEs,
  input  logic               PWRITEs,
  input  logic [ADDR_W-1:0]  PADDRs,
  input  logic [SDATA_W-1:0] PWDATAs,
  output logic [SDATA_W-1:0] PRDATAs,
  output logic               PREADYs,
  output logic               PSELm,
  output logic               PENABLEm,
  output logic               PWRITEm,
  output logic [ADDR_W-1:0]  PADDRm,
  output logic [MDATA_W-1:0] PWDATAm,
  input  logic [MDATA_W-1:0] PRDATAm,
  input  logic               PREADYm
);

  import apb_upsizer_pkg::*;

  localparam int TW = ADDR_W - WADDR_LSB;

  // Sequence / request context
  state_t             state_q;
  logic [1:0]         seq_q;
  logic [1:0]         last_q;
  logic               mrd_q;
  logic               wr_q;
  logic               hi_q;
  logic [TW-1:0]      tag_q;
  logic [SDATA_W-1:0] wdata_q;
  logic               preadys_q;

  // Low-half write buffer
  logic [SDATA_W-1:0] wbuf_q;
  logic [TW-1:0]      wtag_q;
  logic               wvld_q;

`ifdef APB_UPSIZER_RCACHE_EN
  // High-half read cache
  logic [SDATA_W-1:0] rbuf_q;
  logic [TW-1:0]      rtag_q;
  logic               rvld_q;
  logic               hit_q;
  logic               done_wr;
  logic [TW-1:0]      done_tag;
`endif

  // Acceptance decode
  logic          accept;
  logic [TW-1:0] s_tag;
  logic          s_hi;
  logic          w_match;
  logic          need_flush;
  logic          rd_hit;
  logic          main_rd;
  logic          main_wr;
  logic          need_master;
  logic [1:0]    first_seq;
  logic [1:0]    last_seq;

  // Master phase command
  logic               in_idle;
  logic [TW-1:0]      cur_tag;
  logic [SDATA_W-1:0] cur_wdata;
  logic               cur_mrd;
  logic [1:0]         ph;
  logic               m_start;
  op_t                m_op;
  logic [TW-1:0]      m_tag;
  logic [MDATA_W-1:0] m_wdata;
  logic               m_done;
  logic [MDATA_W-1:0] m_rdata;

  // Byte lane bit 0 carries no meaning on a halfword bus.
  logic addr_lsb_unused;
  assign addr_lsb_unused = PADDRs[0];

  always_comb begin
    s_tag      = PADDRs[ADDR_W-1:WADDR_LSB];
    s_hi       = PADDRs[1];
    accept     = (state_q == IDLE) && PSELs && PENABLEs;
    w_match    = wvld_q && (wtag_q == s_tag);
    // Reads never see a parked low half; writes only conflict on another word.
    need_flush = wvld_q && (!PWRITEs || !w_match);
`ifdef APB_UPSIZER_RCACHE_EN
    // A flush to the cached word would invalidate the entry before the read.
    rd_hit = !PWRITEs && s_hi && rvld_q && (rtag_q == s_tag) &&
             !(need_flush && (wtag_q == rtag_q));
`else
    rd_hit = 1'b0;
`endif
    main_wr     = PWRITEs && s_hi;
    main_rd     = PWRITEs ? (s_hi && !w_match) : !rd_hit;
    need_master = need_flush || main_rd || main_wr;
    first_seq   = need_flush ? PH_FLUSH_RD : PH_MAIN0;
    if (main_rd && main_wr) begin
      last_seq = PH_MAIN1;
    end else if (main_rd || main_wr) begin
      last_seq = PH_MAIN0;
    end else begin
      last_seq = PH_FLUSH_WR;
    end
  end

  // The first phase is issued from the live request in the accept cycle;
  // chained phases use the latched copy. Chained writes take their merge
  // half straight from PRDATAm, which is valid in the completing cycle.
  always_comb begin
    in_idle   = (state_q == IDLE);
    cur_tag   = in_idle ? s_tag : tag_q;
    cur_wdata = in_idle ? PWDATAs : wdata_q;
    cur_mrd   = in_idle ? main_rd : mrd_q;
    ph        = in_idle ? first_seq : (seq_q + 2'd1);
    m_start   = (accept && need_master) ||
                ((state_q == M_ACCESS) && m_done && (seq_q != last_q));
    m_op      = OP_RD;
    m_tag     = cur_tag;
    m_wdata   = '0;
    case (ph)
      PH_FLUSH_RD: begin
        m_tag = wtag_q;
      end
      PH_FLUSH_WR: begin
        m_op    = OP_WR;
        m_tag   = wtag_q;
        m_wdata = {PRDATAm[MDATA_W-1:SDATA_W], wbuf_q};
      end
      PH_MAIN0: begin
        if (!cur_mrd) begin
          m_op    = OP_WR;
          m_wdata = {cur_wdata, wbuf_q};
        end
      end
      default: begin
        m_op    = OP_WR;
        m_wdata = {cur_wdata, PRDATAm[SDATA_W-1:0]};
      end
    endcase
  end

`ifdef APB_UPSIZER_RCACHE_EN
  // Phase finishing this cycle: is it a write, and to which word.
  always_comb begin
    done_wr  = (seq_q == PH_FLUSH_WR) || (seq_q == PH_MAIN1) ||
               ((seq_q == PH_MAIN0) && !mrd_q && wr_q);
    done_tag = (seq_q == PH_FLUSH_WR) ? wtag_q : tag_q;
  end
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      seq_q     <= 2'd0;
      last_q    <= 2'd0;
      mrd_q     <= 1'b0;
      wr_q      <= 1'b0;
      hi_q      <= 1'b0;
      tag_q     <= '0;
      wdata_q   <= '0;
      preadys_q <= 1'b0;
      wbuf_q    <= '0;
      wtag_q    <= '0;
      wvld_q    <= 1'b0;
`ifdef APB_UPSIZER_RCACHE_EN
      rbuf_q    <= '0;
      rtag_q    <= '0;
      rvld_q    <= 1'b0;
      hit_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            tag_q   <= s_tag;
            hi_q    <= s_hi;
            wr_q    <= PWRITEs;
            wdata_q <= PWDATAs;
            mrd_q   <= main_rd;
            last_q  <= last_seq;
`ifdef APB_UPSIZER_RCACHE_EN
            hit_q   <= rd_hit;
`endif
            if (need_master) begin
              state_q <= M_SETUP;
              seq_q   <= first_seq;
            end else begin
              state_q   <= RESP;
              preadys_q <= 1'b1;
              if (PWRITEs && !s_hi) begin
                wbuf_q <= PWDATAs;
                wtag_q <= s_tag;
                wvld_q <= 1'b1;
              end
            end
          end
        end
        M_SETUP: begin
          state_q <= M_ACCESS;
        end
        M_ACCESS: begin
          if (m_done) begin
            // Buffer drains on the flush write or on the paired high write.
            if ((seq_q == PH_FLUSH_WR) || ((seq_q == PH_MAIN0) && !mrd_q && wr_q)) begin
              wvld_q <= 1'b0;
            end
`ifdef APB_UPSIZER_RCACHE_EN
            if (done_wr && (done_tag == rtag_q)) begin
              rvld_q <= 1'b0;
            end
`endif
            if (seq_q == last_q) begin
              state_q   <= RESP;
              preadys_q <= 1'b1;
              // Low write that had to flush first parks now (wins over clear).
              if (wr_q && !hi_q) begin
                wbuf_q <= wdata_q;
                wtag_q <= tag_q;
                wvld_q <= 1'b1;
              end
`ifdef APB_UPSIZER_RCACHE_EN
              if (!wr_q && !hi_q) begin
                rbuf_q <= PRDATAm[MDATA_W-1:SDATA_W];
                rtag_q <= tag_q;
                rvld_q <= 1'b1;
              end
`endif
            end else begin
              state_q <= M_SETUP;
              seq_q   <= seq_q + 2'd1;
            end
          end
        end
        RESP: begin
          state_q   <= IDLE;
          preadys_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  apb_upsizer_mport #(
    .AW(ADDR_W),
    .DW(MDATA_W)
  ) u_mport (
    .clk       (PCLK),
    .rst       (PRESET),
    .start_i   (m_start),
    .op_i      (m_op),
    .addr_i    ({m_tag, {WADDR_LSB{1'b0}}}),
    .wdata_i   (m_wdata),
    .pready_i  (PREADYm),
    .prdata_i  (PRDATAm),
    .psel_o    (PSELm),
    .penable_o (PENABLEm),
    .pwrite_o  (PWRITEm),
    .paddr_o   (PADDRm),
    .pwdata_o  (PWDATAm),
    .done_o    (m_done),
    .rdata_o   (m_rdata)
  );

  assign PREADYs = preadys_q;

  // Read data is driven only during a read response.
  always_comb begin
    PRDATAs = '0;
    if ((state_q == RESP) && !wr_q) begin
`ifdef APB_UPSIZER_RCACHE_EN
      if (hit_q) begin
        PRDATAs = rbuf_q;
      end else
`endif
      if (hi_q) begin
        PRDATAs = m_rdata[MDATA_W-1:SDATA_W];
      end else begin
        PRDATAs = m_rdata[SDATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_apb_upsizer.sv
module tb_apb_upsizer;

  logic        PCLK;
  logic        PRESET;
  logic        PSELs;
  logic        PENABLEs;
  logic        PWRITEs;
  logic [7:0]  PADDRs;
  logic [15:0] PWDATAs;
  logic [15:0] PRDATAs;
  logic        PREADYs;
  logic        PSELm;
  logic        PENABLEm;
  logic        PWRITEm;
  logic [7:0]  PADDRm;
  logic [31:0] PWDATAm;
  logic [31:0] PRDATAm;
  logic        PREADYm;

  apb_upsizer dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PSELs    (PSELs),
    .PENABLEs (PENABLEs),
    .PWRITEs  (PWRITEs),
    .PADDRs   (PADDRs),
    .PWDATAs  (PWDATAs),
    .PRDATAs  (PRDATAs),
    .PREADYs  (PREADYs),
    .PSELm    (PSELm),
    .PENABLEm (PENABLEm),
    .PWRITEm  (PWRITEm),
    .PADDRm   (PADDRm),
    .PWDATAm  (PWDATAm),
    .PRDATAm  (PRDATAm),
    .PREADYm  (PREADYm)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard of expected master transfers
  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } mtxn_t;
  mtxn_t exp_m_q[$];

  task automatic exp_m(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    mtxn_t t;
    t.wr   = wr;
    t.addr = addr;
    t.data = data;
    exp_m_q.push_back(t);
  endtask

  // 32-bit completer model with programmable wait states
  logic [31:0] mem [64];
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic [7:0]  setup_addr;
  logic [31:0] setup_wdata;

  always @(negedge PCLK) begin
    if (PSELm && !PENABLEm) begin
      setup_addr  = PADDRm;
      setup_wdata = PWDATAm;
      wcnt        = 0;
      PREADYm     = 1'b0;
    end else if (PSELm && PENABLEm) begin
      if (wcnt >= wait_cfg) begin
        mtxn_t e;
        PREADYm = 1'b1;
        PRDATAm = mem[PADDRm[7:2]];
        check("m_stable", {PADDRm, PWDATAm}, {setup_addr, setup_wdata});
        if (exp_m_q.size() == 0) begin
          check("m_unexpected_txn", exp_m_q.size(), 1);
        end else begin
          e = exp_m_q.pop_front();
          check("m_cmd", {PWRITEm, PADDRm}, {e.wr, e.addr});
          if (e.wr) check("m_wdata", PWDATAm, e.data);
        end
        if (PWRITEm) mem[PADDRm[7:2]] = PWDATAm;
      end else begin
        PREADYm = 1'b0;
        wcnt++;
      end
    end else begin
      PREADYm = 1'b0;
    end
  end

  // One 16-bit APB transfer; latency counted in cycles from the accept edge
  // to the response cycle (1 = buffered only, 3 = one master access).
  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata, input int exp_lat);
    int          lat;
    logic        got;
    logic [15:0] rd;
    lat = 0;
    got = 1'b0;
    rd  = '0;
    @(negedge PCLK);
    PSELs    = 1'b1;
    PENABLEs = 1'b0;
    PWRITEs  = wr;
    PADDRs   = addr;
    PWDATAs  = wdata;
    @(negedge PCLK);
    PENABLEs = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge PCLK);
      lat++;
      if (PREADYs) begin
        got = 1'b1;
        rd  = PRDATAs;
      end
    end
    $display("xfer %s addr=0x%02h wdata=0x%04h rdata=0x%04h lat=%0d",
             wr ? "WR" : "RD", addr, wdata, rd, lat);
    check("xfer_timeout", got, 1'b1);
    check("xfer_latency", lat, exp_lat);
    if (wr) check("wr_prdata_zero", rd, 16'h0);
    else    check("rd_data", rd, exp_rdata);
    check("m_pending", exp_m_q.size(), 0);
    @(negedge PCLK);
    PSELs    = 1'b0;
    PENABLEs = 1'b0;
  endtask

  logic got;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {16'hC000 | 16'(i), 16'h0D00 | 16'(i)};
    PRESET   = 1'b1;
    PSELs    = 1'b0;
    PENABLEs = 1'b0;
    PWRITEs  = 1'b0;
    PADDRs   = '0;
    PWDATAs  = '0;
    PREADYm  = 1'b0;
    PRDATAm  = '0;
    repeat (3) @(negedge PCLK);
    check("reset_outputs", {PSELm, PENABLEm, PWRITEm, PADDRm, PWDATAm, PREADYs, PRDATAs}, 64'h0);
    PRESET = 1'b0;

    // Low then high write of one word: buffered, then one merged write
    apb_xfer(1'b1, 8'h44, 16'h5678, 16'h0, 1);
    exp_m(1'b1, 8'h44, 32'h1234_5678);
    apb_xfer(1'b1, 8'h46, 16'h1234, 16'h0, 3);

    // Lone high write: read-modify-write
    mem[8'h48 >> 2] = 32'hAAAA_5555;
    exp_m(1'b0, 8'h48, 32'h0);
    exp_m(1'b1, 8'h48, 32'hBEEF_5555);
    apb_xfer(1'b1, 8'h4A, 16'hBEEF, 16'h0, 5);

    // Low / high read pair
    mem[8'h48 >> 2] = 32'hABCD_1234;
    exp_m(1'b0, 8'h48, 32'h0);
    apb_xfer(1'b0, 8'h48, 16'h0, 16'h1234, 3);
`ifdef APB_UPSIZER_RCACHE_EN
    apb_xfer(1'b0, 8'h4A, 16'h0, 16'hABCD, 1);
`else
    exp_m(1'b0, 8'h48, 32'h0);
    apb_xfer(1'b0, 8'h4A, 16'h0, 16'hABCD, 3);
`endif

    // Parked low half flushed by a read of another word
    mem[8'h44 >> 2] = 32'h9999_8888;
    mem[8'h50 >> 2] = 32'hCAFE_F00D;
    apb_xfer(1'b1, 8'h44, 16'h1111, 16'h0, 1);
    exp_m(1'b0, 8'h44, 32'h0);
    exp_m(1'b1, 8'h44, 32'h9999_1111);
    exp_m(1'b0, 8'h50, 32'h0);
    apb_xfer(1'b0, 8'h50, 16'h0, 16'hF00D, 7);
    check("flush_mem", mem[8'h44 >> 2], 32'h9999_1111);

    // Master wait states: response delayed, command stable
    wait_cfg = 3;
    exp_m(1'b0, 8'h60, 32'h0);
    apb_xfer(1'b0, 8'h60, 16'h0, mem[8'h60 >> 2][15:0], 6);
    apb_xfer(1'b1, 8'h64, 16'h2222, 16'h0, 1);
    exp_m(1'b1, 8'h64, 32'h3333_2222);
    apb_xfer(1'b1, 8'h66, 16'h3333, 16'h0, 6);
    wait_cfg = 0;

    // Reset during a flush access
    mem[8'h70 >> 2] = 32'h5A5A_0000;
    apb_xfer(1'b1, 8'h70, 16'h7777, 16'h0, 1);
    wait_cfg = 10;
    @(negedge PCLK);
    PSELs    = 1'b1;
    PENABLEs = 1'b0;
    PWRITEs  = 1'b0;
    PADDRs   = 8'h80;
    @(negedge PCLK);
    PENABLEs = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge PCLK);
      if (PSELm && PENABLEm) got = 1'b1;
    end
    check("rst_reach_access", got, 1'b1);
    check("rst_flush_addr", {PWRITEm, PADDRm}, {1'b0, 8'h70});
    #2 PRESET = 1'b1;
    #1;
    check("rst_mid_outputs", {PSELm, PENABLEm, PWRITEm, PADDRm, PWDATAm, PREADYs, PRDATAs}, 64'h0);
    @(negedge PCLK);
    PSELs    = 1'b0;
    PENABLEs = 1'b0;
    PRESET   = 1'b0;
    wait_cfg = 0;
    exp_m_q.delete();

    // After reset the parked half is gone: plain read, then RMW high write
    exp_m(1'b0, 8'h80, 32'h0);
    apb_xfer(1'b0, 8'h80, 16'h0, mem[8'h80 >> 2][15:0], 3);
    check("rst_no_flush", mem[8'h70 >> 2], 32'h5A5A_0000);
    exp_m(1'b0, 8'h70, 32'h0);
    exp_m(1'b1, 8'h70, 32'hABAB_0000);
    apb_xfer(1'b1, 8'h72, 16'hABAB, 16'h0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
